// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between fetch and load/store.
// Data wins contests, except when fetch has been denied STARVE_LIMIT cycles in a row.
// The response one cycle after an issue is routed to the requester that issued it.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_request,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_masking,
    input  logic              mem_valid,
    input  logic [31:0]       mem_read_data,
    output logic              err
);

    localparam int unsigned          CNT_W = 4;
    localparam logic [CNT_W-1:0]     LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             pend_q;
    logic             owner_q;
    logic             err_q;
    logic             err_d;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst) begin
            if (if_req && d_req) begin
                if (starve_q >= LIMIT) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Issue mux: drive the RAM with the granted requester's fields.
    always_comb begin
        mem_request    = if_gnt | d_gnt;
        mem_address    = if_addr;
        mem_w_en       = 1'b0;
        mem_masking    = 4'b0000;
        mem_write_data = d_wdata;
        if (d_gnt) begin
            mem_address = d_addr;
            mem_w_en    = d_we;
            mem_masking = d_mask;
        end
    end

    // Consecutive-denial counter for fetch, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Sticky error: a response without an issue, or an issue without a response.
    always_comb begin
        err_d = err_q | (mem_valid & ~pend_q) | (pend_q & ~mem_valid);
    end

    // State registers: owner tracking, starvation counter, error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= 1'b0;
            owner_q  <= 1'b0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= mem_request;
            owner_q  <= d_gnt;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Response routing back to the issuing requester.
    always_comb begin
        if_rvalid = mem_valid & pend_q & ~owner_q;
        d_rvalid  = mem_valid & pend_q & owner_q;
        if_rdata  = mem_read_data;
        d_rdata   = mem_read_data;
        err       = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency RAM model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_mask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_request;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [3:0]        mem_masking;
    logic              mem_valid;
    logic [31:0]       mem_read_data;
    logic              err;

    logic              ram_valid = 1'b0;
    logic              force_valid;
    logic [31:0]       ram [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_valid = ram_valid | force_valid;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_request(mem_request), .mem_w_en(mem_w_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_masking(mem_masking),
        .mem_valid(mem_valid), .mem_read_data(mem_read_data), .err(err)
    );

    // RAM wrapper model: one request per cycle, response one cycle later.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + 32'(i);
    end

    always @(posedge clk) begin
        ram_valid <= mem_request;
        if (mem_request) begin
            if (mem_w_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_masking[b]) ram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
            end else begin
                mem_read_data <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] pat;
    logic        p;
    logic        pp;

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_mask = '0; force_valid = 1'b0;
        mem_read_data = '0;

        // Reset state
        tick(); #2;
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_mem_req", 32'(mem_request), 32'd0);
        check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        if_req = 1'b0;
        tick(); rst = 1'b1;

        // Single fetch
        tick(); if_req = 1'b1; if_addr = 8'h10; #2;
        check("fetch_gnt", {30'd0, if_gnt, d_gnt}, 32'b10);
        check("fetch_mreq", 32'(mem_request), 32'd1);
        check("fetch_addr", 32'(mem_address), 32'h10);
        check("fetch_wen_mask", {27'd0, mem_w_en, mem_masking}, 32'd0);
        tick(); if_req = 1'b0; #2;
        check("fetch_rv", {30'd0, if_rvalid, d_rvalid}, 32'b10);
        check("fetch_rdata", if_rdata, 32'h1000_0010);

        // Store then load
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011; #2;
        check("st_gnt", {30'd0, if_gnt, d_gnt}, 32'b01);
        check("st_wen_mask", {27'd0, mem_w_en, mem_masking}, 32'b1_0011);
        check("st_wdata", mem_write_data, 32'hDEAD_BEEF);
        tick(); d_req = 1'b0; d_we = 1'b0; d_mask = 4'b0000; #2;
        check("st_ack", {30'd0, if_rvalid, d_rvalid}, 32'b01);
        tick(); #2;
        check("st_ack_once", 32'(d_rvalid), 32'd0);
        tick(); d_req = 1'b1; d_addr = 8'h05; #2;
        check("ld_gnt", 32'(d_gnt), 32'd1);
        check("ld_wen", 32'(mem_w_en), 32'd0);
        tick(); d_req = 1'b0; #2;
        check("ld_rv", {30'd0, if_rvalid, d_rvalid}, 32'b01);
        check("ld_rdata", d_rdata, 32'h1000_BEEF);

        // Contention: D,D,D,D,I,D,D,D,D,I,D,D (bit i = 1 means fetch wins cycle i)
        pat = 12'b0010_0001_0000;
        pp  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(); if_req = 1'b1; if_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; #2;
            p = pat[i];
            check($sformatf("cont_gnt%0d", i), {30'd0, if_gnt, d_gnt}, {30'd0, p, ~p});
            check($sformatf("cont_addr%0d", i), 32'(mem_address), p ? 32'h20 : 32'h30);
            if (i > 0) begin
                check($sformatf("cont_rv%0d", i), {30'd0, if_rvalid, d_rvalid}, {30'd0, pp, ~pp});
                check($sformatf("cont_rdata%0d", i), pp ? if_rdata : d_rdata,
                      pp ? 32'h1000_0020 : 32'h1000_0030);
            end
            pp = p;
        end
        tick(); if_req = 1'b0; d_req = 1'b0; #2;
        check("cont_rv_last", {30'd0, if_rvalid, d_rvalid}, 32'b01);

        // Back-to-back alternation
        tick(); if_req = 1'b1; if_addr = 8'h11; #2;
        check("alt_gnt0", {30'd0, if_gnt, d_gnt}, 32'b10);
        tick(); if_req = 1'b0; d_req = 1'b1; d_addr = 8'h12; #2;
        check("alt_gnt1", {30'd0, if_gnt, d_gnt}, 32'b01);
        check("alt_rv1", {30'd0, if_rvalid, d_rvalid}, 32'b10);
        check("alt_rdata1", if_rdata, 32'h1000_0011);
        tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 8'h13; #2;
        check("alt_gnt2", {30'd0, if_gnt, d_gnt}, 32'b10);
        check("alt_rv2", {30'd0, if_rvalid, d_rvalid}, 32'b01);
        check("alt_rdata2", d_rdata, 32'h1000_0012);
        tick(); if_req = 1'b0; #2;
        check("alt_rv3", {30'd0, if_rvalid, d_rvalid}, 32'b10);
        check("alt_rdata3", if_rdata, 32'h1000_0013);

        // Reset mid-flight
        tick(); d_req = 1'b1; d_addr = 8'h14; #2;
        check("rmf_gnt", 32'(d_gnt), 32'd1);
        rst = 1'b0; #1;
        check("rmf_gnt_rst", {30'd0, if_gnt, d_gnt}, 32'd0);
        check("rmf_mreq_rst", 32'(mem_request), 32'd0);
        tick(); #2;
        check("rmf_rv_rst", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("rmf_err_rst", 32'(err), 32'd0);
        check("rmf_gnt_held", 32'(d_gnt), 32'd0);
        tick(); rst = 1'b1; #2;
        check("rmf_resume_gnt", 32'(d_gnt), 32'd1);
        check("rmf_resume_addr", 32'(mem_address), 32'h14);
        tick(); d_req = 1'b0; #2;
        check("rmf_resume_rv", {30'd0, if_rvalid, d_rvalid}, 32'b01);
        check("rmf_resume_rdata", d_rdata, 32'h1000_0014);
        check("rmf_no_err", 32'(err), 32'd0);

        // Protocol error: response with no issue
        tick(); force_valid = 1'b1; #2;
        check("perr_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("perr_err_pre", 32'(err), 32'd0);
        tick(); force_valid = 1'b0; #2;
        check("perr_err", 32'(err), 32'd1);
        check("perr_rv2", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        tick(); tick(); #2;
        check("perr_sticky", 32'(err), 32'd1);
        rst = 1'b0; #1;
        check("perr_clear", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported instruction/data RAM wrapper (one request per cycle, response `valid` one cycle later) between the pipeline's instruction-fetch port and its load/store port. It issues at most one access per cycle, gives data accesses priority with a bounded-starvation guarantee for fetch, and routes each returning response to the requester that issued it. It sits between the core's IF/MEM stages and the RAM wrapper.

## Interface

Parameters:
- `ADDR_W`, 8: word-address width shared by both requesters and the RAM.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles after which fetch wins the next contest; legal range 1..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch issued this cycle (combinational).
- `if_rvalid`  out  1  fetch response valid.
- `if_rdata`  out  32  fetch response data.
- `d_req`  in  1  data request; held until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  32  store data.
- `d_mask`  in  4  store byte enables.
- `d_gnt`  out  1  data access issued this cycle (combinational).
- `d_rvalid`  out  1  data response valid (load data, or store acknowledge).
- `d_rdata`  out  32  load data.
- `mem_request`  out  1  RAM request.
- `mem_w_en`  out  1  RAM write enable.
- `mem_address`  out  ADDR_W  RAM word address.
- `mem_write_data`  out  32  RAM write data.
- `mem_masking`  out  4  RAM byte enables.
- `mem_valid`  in  1  RAM response valid, one cycle after `mem_request`.
- `mem_read_data`  in  32  RAM read data.
- `err`  out  1  sticky protocol error.

## Operation

- Arbitration is combinational, from `if_req`, `d_req`, and `starve_q`:
  - Only one request is active: that requester is granted.
  - Both are active and `starve_q < STARVE_LIMIT`: data is granted.
  - Both are active and `starve_q == STARVE_LIMIT`: fetch is granted.
- `mem_request = if_gnt | d_gnt`. The issue mux selects the fields of the granted requester.
- When fetch is granted, `mem_w_en = 0` and `mem_masking = 4'b0000`. `mem_write_data` is don't-care.
- `starve_q` is a 4-bit counter:
  - It increments when `if_req & !if_gnt`.
  - It clears when `if_gnt`, or when `if_req` is low.
  - It saturates at `STARVE_LIMIT`.
- Owner tracking uses two registers, `pend_q` and `owner_q` (0 = fetch, 1 = data). Each cycle they load the issue result: `pend_q <= mem_request`, `owner_q <= d_gnt`.
- Response routing:
  - `if_rvalid = mem_valid & pend_q & !owner_q`.
  - `d_rvalid = mem_valid & pend_q & owner_q`.
  - `if_rdata` and `d_rdata` both equal `mem_read_data`.
- Stores also produce a `d_rvalid` pulse, used as the store acknowledge. `d_rdata` is don't-care on a store.
- `err` sets when `mem_valid & !pend_q`, or when `pend_q & !mem_valid`. It holds until reset.
- While `rst` is low, all grants and `mem_request` are forced to 0.

## Timing

- Reset values:
  - `pend_q`, `owner_q`, `starve_q`, `err` = 0.
  - Therefore `if_rvalid = d_rvalid = 0` and `mem_request = 0`.
- Issue and response:
  - An access is issued in cycle N, with `gnt` and `mem_request` both high.
  - Its response appears in N+1, with `mem_valid` and the matching `*_rvalid` high. Latency is exactly 1 cycle.
- Throughput:
  - Back-to-back issue is allowed every cycle.
  - A new issue in N+1 coexists with the response to N.
- Requester rules:
  - Request fields must stay stable while the request is held and not granted.
  - A requester may change its fields or drop its request in the cycle after the grant.
- Simultaneous requests in the same cycle: exactly one grant. Never both.
- Starvation bound: with `d_req` held continuously, fetch is granted no later than its `STARVE_LIMIT+1`-th cycle of request.
- Reset asserted mid-access clears `pend_q`, so any response still in flight is dropped.

## Test plan

- **Single fetch:** `if_req=1`, `if_addr=0x10` for one cycle.
  - Same cycle: `if_gnt=1`, `mem_request=1`, `mem_address=0x10`, `mem_w_en=0`.
  - Next cycle: `if_rvalid=1`, `if_rdata` equals the RAM word at 0x10, `d_rvalid=0`.
- **Store then load:**
  - `d_req=1`, `d_we=1`, `d_addr=0x05`, `d_wdata=0xDEADBEEF`, `d_mask=4'b0011` → `d_rvalid` pulses once.
  - Then load 0x05 → `d_rdata[15:0]=0xBEEF`, upper bytes unchanged.
- **Contention with STARVE_LIMIT=4:** `if_req` and `d_req` held high for 12 cycles.
  - Grant pattern is `D,D,D,D,I,D,D,D,D,I,D,D`.
  - Responses are routed to the matching owner one cycle later.
- **Back-to-back alternation:** fetch in cycle N, data load in N+1, fetch in N+2.
  - `if_rvalid` in N+1, `d_rvalid` in N+2, `if_rvalid` in N+3.
  - No response is lost or misrouted.
- **Reset mid-flight:** grant data in cycle N, then pull `rst` low during N.
  - No `d_rvalid` after reset.
  - All outputs are 0 while in reset.
  - Normal grants resume after release.
- **Protocol error:** force `mem_valid=1` with no prior issue.
  - `err=1` next cycle and stays 1 until `rst`.
  - No `*_rvalid` asserted.
